// File: rtl/demux1x2_32bit_reg_if.sv
// Handshake bundle for the 1:2 registered demux: one upstream stream,
// two downstream streams and the per-output transfer counters.
interface demux1x2_32bit_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             select;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_valid, in_data, select, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  modport slave (
    input  in_valid, in_data, select, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux1x2_32bit_reg.sv
// 1:2 stream demux with a one-entry registered buffer per output and
// a wrapping handshake counter per output.
module demux1x2_32bit_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1x2_32bit_reg_if.slave   bus
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e       state0_q, state0_d;
  buf_state_e       state1_q, state1_d;
  logic [WIDTH-1:0] data0_q,  data0_d;
  logic [WIDTH-1:0] data1_q,  data1_d;
  logic [CNT_W-1:0] cnt0_q,   cnt0_d;
  logic [CNT_W-1:0] cnt1_q,   cnt1_d;

  logic in_ready_c;
  logic in_hs;
  logic out0_hs;
  logic out1_hs;

  // Next-state: drain first, then a load into the same buffer wins (no bubble).
  always_comb begin
    state0_d = state0_q;
    state1_d = state1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    out0_hs    = (state0_q == BUF_FULL) && bus.out0_ready;
    out1_hs    = (state1_q == BUF_FULL) && bus.out1_ready;
    // Only the selected buffer gates acceptance.
    in_ready_c = bus.select ? ((state1_q == BUF_EMPTY) || bus.out1_ready)
                            : ((state0_q == BUF_EMPTY) || bus.out0_ready);
    in_hs      = bus.in_valid && in_ready_c;

    if (out0_hs) begin
      state0_d = BUF_EMPTY;
      cnt0_d   = cnt0_q + CNT_W'(1);
    end
    if (out1_hs) begin
      state1_d = BUF_EMPTY;
      cnt1_d   = cnt1_q + CNT_W'(1);
    end

    if (in_hs && !bus.select) begin
      state0_d = BUF_FULL;
      data0_d  = bus.in_data;
    end
    if (in_hs && bus.select) begin
      state1_d = BUF_FULL;
      data1_d  = bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0_q <= BUF_EMPTY;
      state1_q <= BUF_EMPTY;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = (state0_q == BUF_FULL);
  assign bus.out1_valid = (state1_q == BUF_FULL);
  assign bus.out0_data  = data0_q;
  assign bus.out1_data  = data1_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

endmodule
